// File: rtl/led_pwm_ctrl.sv
// led_pwm_ctrl: multi-channel PWM LED driver with an Avalon-MM slave register
// interface. A shared prescaler and period counter are compared against
// per-channel duty values. Duty writes land in shadow registers and are copied
// to the active set only at a period wrap (or continuously while disabled), so
// a duty change never cuts a period short.
//
// Optional feature macro: LED_PWM_CTRL_IRQ_EN adds the STATUS register
// (bit0 PEND sticky wrap flag, write-1-to-clear; bit1 IE) and the irq output.
//
// Ports:
//   clk, reset_n          single clock, asynchronous active-low reset
//   address               word address (0 CTRL, 1 PRESCALE, 2 PERIOD, 3 CH_EN,
//                         4 STATUS, 8+n DUTY[n])
//   chipselect, write_n   write when chipselect & ~write_n
//   writedata/readdata    32-bit data; readdata is combinational from address
//   out_port              registered PWM outputs, one per channel
//   irq                   registered PEND & IE (only with LED_PWM_CTRL_IRQ_EN)

// Per-channel slice: duty shadow, active copy and registered output.
module led_pwm_chan #(
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             wr_duty,
  input  logic [CNT_W-1:0] wdata,
  input  logic             load,
  input  logic             out_en,
  input  logic             inv,
  input  logic [CNT_W-1:0] cnt,
  output logic [CNT_W-1:0] duty,
  output logic             pwm
);
  logic [CNT_W-1:0] active;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      duty   <= '0;
      active <= '0;
      pwm    <= 1'b0;
    end else begin
      if (wr_duty) duty <= wdata;
      // Non-blocking read of duty: a write on a wrap clk transfers the old value.
      if (load) active <= duty;
      pwm <= inv ^ (out_en & (cnt < active));
    end
  end
endmodule

module led_pwm_ctrl #(
  parameter int CHANNELS = 8,
  parameter int CNT_W    = 8,
  parameter int PRESC_W  = 16,
  parameter int ADDR_W   = 4
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic [ADDR_W-1:0]   address,
  input  logic                chipselect,
  input  logic                write_n,
  input  logic [31:0]         writedata,
  output logic [31:0]         readdata,
  output logic [CHANNELS-1:0] out_port
`ifdef LED_PWM_CTRL_IRQ_EN
  ,
  output logic                irq
`endif
);
  logic                               wr;
  logic                               en, inv;
  logic [PRESC_W-1:0]                 prescale, presc_cnt;
  logic [CNT_W-1:0]                   period, cnt;
  logic [CHANNELS-1:0]                ch_en;
  logic [CHANNELS-1:0][CNT_W-1:0]     duty_sh;
  logic                               tick, wrap, load;
  logic                               unused_ok;

  assign wr        = chipselect & ~write_n;
  assign unused_ok = &{1'b0, writedata};
  // >= compares let a shrunk limit take effect on the very next evaluation.
  assign tick = en & (presc_cnt >= prescale);
  assign wrap = tick & (cnt >= period);
  // While disabled the active copies track the shadows every cycle.
  assign load = ~en | wrap;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      en        <= 1'b0;
      inv       <= 1'b0;
      prescale  <= '0;
      period    <= '0;
      ch_en     <= '0;
      presc_cnt <= '0;
      cnt       <= '0;
    end else begin
      if (wr && address == ADDR_W'(0)) {inv, en} <= writedata[1:0];
      if (wr && address == ADDR_W'(1)) prescale <= writedata[PRESC_W-1:0];
      if (wr && address == ADDR_W'(2)) period   <= writedata[CNT_W-1:0];
      if (wr && address == ADDR_W'(3)) ch_en    <= writedata[CHANNELS-1:0];
      if (!en) begin
        presc_cnt <= '0;
        cnt       <= '0;
      end else if (tick) begin
        presc_cnt <= '0;
        cnt       <= wrap ? '0 : cnt + 1'b1;
      end else begin
        presc_cnt <= presc_cnt + 1'b1;
      end
    end
  end

  for (genvar n = 0; n < CHANNELS; n++) begin : g_ch
    led_pwm_chan #(.CNT_W(CNT_W)) u_ch (
      .clk     (clk),
      .reset_n (reset_n),
      .wr_duty (wr && address == ADDR_W'(8 + n)),
      .wdata   (writedata[CNT_W-1:0]),
      .load    (load),
      .out_en  (en & ch_en[n]),
      .inv     (inv),
      .cnt     (cnt),
      .duty    (duty_sh[n]),
      .pwm     (out_port[n])
    );
  end

`ifdef LED_PWM_CTRL_IRQ_EN
  logic pend, ie, pend_nxt, ie_nxt;

  always_comb begin
    pend_nxt = pend;
    ie_nxt   = ie;
    if (wr && address == ADDR_W'(4)) begin
      if (writedata[0]) pend_nxt = 1'b0;
      ie_nxt = writedata[1];
    end
    // Set after clear so a wrap on the clearing clk keeps PEND.
    if (wrap) pend_nxt = 1'b1;
  end

  // irq registered from next-state so it follows a clear on the same edge.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      pend <= 1'b0;
      ie   <= 1'b0;
      irq  <= 1'b0;
    end else begin
      pend <= pend_nxt;
      ie   <= ie_nxt;
      irq  <= pend_nxt & ie_nxt;
    end
  end
`endif

  always_comb begin
    readdata = '0;
    case (address)
      ADDR_W'(0): readdata = {30'b0, inv, en};
      ADDR_W'(1): readdata = 32'(prescale);
      ADDR_W'(2): readdata = 32'(period);
      ADDR_W'(3): readdata = 32'(ch_en);
`ifdef LED_PWM_CTRL_IRQ_EN
      ADDR_W'(4): readdata = {30'b0, ie, pend};
`endif
      default: begin
        for (int n = 0; n < CHANNELS; n++)
          if (address == ADDR_W'(8 + n)) readdata = 32'(duty_sh[n]);
      end
    endcase
  end
endmodule

// File: tb/tb_led_pwm_ctrl.sv
// Self-checking bench for led_pwm_ctrl: register readback table, PWM waveform
// checks against hand-derived formulas, double-buffer and period-shrink corner
// cases, asynchronous reset, and the optional interrupt path.
module tb_led_pwm_ctrl;
  localparam int CH = 6, CW = 8, PW = 16, AW = 4;
`ifdef LED_PWM_CTRL_IRQ_EN
  localparam logic [31:0] STAT_EXP = 32'h2;
`else
  localparam logic [31:0] STAT_EXP = 32'h0;
`endif

  logic          clk = 1'b0, reset_n = 1'b0;
  logic [AW-1:0] address = '0;
  logic          chipselect = 1'b0, write_n = 1'b1;
  logic [31:0]   writedata = '0;
  logic [31:0]   readdata;
  logic [CH-1:0] out_port;
`ifdef LED_PWM_CTRL_IRQ_EN
  logic          irq;
`endif

  led_pwm_ctrl #(.CHANNELS(CH), .CNT_W(CW), .PRESC_W(PW), .ADDR_W(AW)) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .address    (address),
    .chipselect (chipselect),
    .write_n    (write_n),
    .writedata  (writedata),
    .readdata   (readdata),
    .out_port   (out_port)
`ifdef LED_PWM_CTRL_IRQ_EN
    ,
    .irq        (irq)
`endif
  );

  always #5 clk = ~clk;

  int          tests = 0, fails = 0;
  logic [31:0] exp_q[$];
  logic [31:0] rv;

  typedef struct {
    int          a;
    logic [31:0] d;
    logic [31:0] e;
  } vec_t;
  vec_t tbl[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic check_pop(input string name, input logic [31:0] act);
    if (exp_q.size() == 0) begin
      tests++;
      fails++;
      $display("FAIL %s: scoreboard empty, got 0x%0h", name, act);
    end else begin
      check(name, act, exp_q.pop_front());
    end
  endtask

  // Called at posedge+1; the write lands on the next posedge.
  task automatic wr(input int a, input logic [31:0] d);
    address    = AW'(a);
    writedata  = d;
    chipselect = 1'b1;
    write_n    = 1'b0;
    @(posedge clk);
    #1;
    chipselect = 1'b0;
    write_n    = 1'b1;
  endtask

  task automatic rd(input int a, output logic [31:0] d);
    address = AW'(a);
    #1;
    d = readdata;
  endtask

  initial begin
    // Reset state
    #12;
    check("rst_out", 32'(out_port), 32'h0);
    foreach (tbl[i]) ; // no-op, keeps table empty until filled below
    for (int a = 0; a < 16; a++) begin
      rd(a, rv);
      check($sformatf("rst_rd%0d", a), rv, 32'h0);
    end
    @(posedge clk); #1;
    reset_n = 1'b1;

    // Register readback table
    tbl.push_back('{1,  32'hFFFF_ABCD, 32'h0000_ABCD});
    tbl.push_back('{2,  32'h0000_01FF, 32'h0000_00FF});
    tbl.push_back('{3,  32'hFFFF_FFFF, 32'h0000_003F});
    tbl.push_back('{0,  32'h0000_00FE, 32'h0000_0002});
    tbl.push_back('{4,  32'h0000_0002, STAT_EXP});
    tbl.push_back('{5,  32'h0000_0055, 32'h0});
    tbl.push_back('{7,  32'hFFFF_FFFF, 32'h0});
    tbl.push_back('{8,  32'h0000_01A5, 32'h0000_00A5});
    tbl.push_back('{13, 32'h0000_003C, 32'h0000_003C});
    tbl.push_back('{14, 32'h0000_0077, 32'h0});
    tbl.push_back('{15, 32'h0000_0011, 32'h0});
    foreach (tbl[i]) begin
      wr(tbl[i].a, tbl[i].d);
      exp_q.push_back(tbl[i].e);
      rd(tbl[i].a, rv);
      check_pop($sformatf("reg_rd%0d", tbl[i].a), rv);
    end

    // Basic PWM: period 10, duty 3. Output after edge k reflects cnt=(k-1)%10.
    wr(0, 0); wr(1, 0); wr(2, 9); wr(8, 3); wr(3, 1); wr(0, 1);
    for (int k = 1; k <= 30; k++) begin
      exp_q.push_back(32'(((k - 1) % 10) < 3));
      @(posedge clk); #1;
      check_pop($sformatf("pwm3_k%0d", k), 32'(out_port[0]));
    end

    // Mid-period duty write: current period keeps 3, next uses 7.
    wr(8, 7);
    rd(8, rv);
    check("duty_shadow_rd", rv, 32'h7);
    for (int k = 32; k <= 49; k++) begin
      exp_q.push_back(32'(((k - 1) % 10) < ((k <= 40) ? 3 : 7)));
      @(posedge clk); #1;
      check_pop($sformatf("pwm7_k%0d", k), 32'(out_port[0]));
    end
    // Duty write on the wrap clk: the wrap takes the old 7, new 2 one period later.
    wr(8, 2);
    for (int k = 51; k <= 70; k++) begin
      exp_q.push_back(32'(((k - 1) % 10) < ((k <= 60) ? 7 : 2)));
      @(posedge clk); #1;
      check_pop($sformatf("pwm_wrapwr_k%0d", k), 32'(out_port[0]));
    end

    // Inverted outputs, DUTY=0 and DUTY>PERIOD: out1 const 1, out2 const 0.
    wr(0, 0); wr(9, 0); wr(10, 255); wr(3, 7); wr(0, 3);
    for (int k = 1; k <= 15; k++) begin
      exp_q.push_back(32'h1);
      @(posedge clk); #1;
      check_pop($sformatf("inv_k%0d", k), 32'(out_port[2:1]));
    end

    // Asynchronous reset mid-run
    #2;
    reset_n = 1'b0;
    #1;
    check("arst_out", 32'(out_port), 32'h0);
    rd(0, rv);  check("arst_ctrl", rv, 32'h0);
    rd(3, rv);  check("arst_chen", rv, 32'h0);
    rd(10, rv); check("arst_duty2", rv, 32'h0);
    @(posedge clk); @(posedge clk); #1;
    check("arst_hold_out", 32'(out_port), 32'h0);
    rd(2, rv);  check("arst_hold_period", rv, 32'h0);
    reset_n = 1'b1;
    @(posedge clk); #1;

    // Period shrink below the running count: wrap on next tick, then 12-clk period.
    wr(1, 3); wr(2, 4); wr(8, 1); wr(3, 1); wr(0, 1);
    repeat (16) @(posedge clk);
    #1;
    wr(2, 2);
    for (int k = 18; k <= 56; k++) begin
      exp_q.push_back(32'((k >= 21) && (((k - 21) % 12) < 4)));
      @(posedge clk); #1;
      check_pop($sformatf("shrink_k%0d", k), 32'(out_port[0]));
    end

`ifdef LED_PWM_CTRL_IRQ_EN
    // Interrupt: period 4 clks, first wrap on edge 4 after enable.
    wr(0, 0); wr(1, 0); wr(2, 3); wr(4, 3); wr(0, 1);
    repeat (3) @(posedge clk);
    #1;
    check("irq_before_wrap", 32'(irq), 32'h0);
    @(posedge clk); #1;
    check("irq_on_wrap", 32'(irq), 32'h1);
    rd(4, rv); check("stat_pend", rv, 32'h3);
    wr(4, 3);
    check("irq_cleared", 32'(irq), 32'h0);
    rd(4, rv); check("stat_cleared", rv, 32'h2);
    repeat (2) @(posedge clk);
    #1;
    wr(4, 3);
    check("irq_clear_vs_wrap", 32'(irq), 32'h1);
    rd(4, rv); check("stat_set_wins", rv, 32'h3);
`else
    rd(4, rv); check("stat_absent", rv, 32'h0);
`endif

    if (exp_q.size() != 0) begin
      tests++;
      fails++;
      $display("FAIL scoreboard_leftover: %0d entries, expected 0", exp_q.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
